// File: rtl/uart_fifo.sv
// Single-clock byte FIFO for the UART TX/RX paths, with occupancy and sticky error status.
// Define UART_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module uart_fifo #(
    parameter int DATA_W          = 8,
    parameter int DEPTH_LOG2      = 4,
    parameter int ALMOST_FULL_THR = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic                  pop_i,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic                  rd_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic [DEPTH_LOG2:0]   count_o,
    input  logic                  clr_err_i,
    output logic                  overflow_o,
    output logic                  underflow_o
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   THR_C   = (DEPTH_LOG2+1)'(ALMOST_FULL_THR);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  pop_acc, push_acc, mem_we;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
    assign pop_acc  = pop_i && (count_q != '0);
    assign push_acc = push_i && ((count_q != DEPTH_C) || pop_acc);
    assign mem_we   = push_acc && !flush_i && !rst_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            // A new error event wins over a clear in the same cycle.
            if (push_i && !push_acc)  overflow_d = 1'b1;
            else if (clr_err_i)       overflow_d = 1'b0;
            if (pop_i && !pop_acc)    underflow_d = 1'b1;
            else if (clr_err_i)       underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[wr_ptr_q] <= wr_data_i;
    end

`ifdef UART_FIFO_FWFT_EN
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign rd_valid_o = (count_q != '0);
`else
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (!flush_i && pop_acc) begin
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
`endif

    assign count_o       = count_q;
    assign full_o        = (count_q == DEPTH_C);
    assign empty_o       = (count_q == '0);
    assign almost_full_o = (count_q >= THR_C);
    assign overflow_o    = overflow_q;
    assign underflow_o   = underflow_q;
endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
Synchronous single-clock byte FIFO that answers the uart_controller FIFO handshake.
- One instance sits between the host and the controller's TX path. The controller's tx_fifo_pop_o drives pop_i.
- One instance sits on the RX path. The controller's rx_fifo_push_o and rx_data_o drive push_i and wr_data_i.
- Provides occupancy, almost-full, and sticky overflow/underflow status for software and flow control.

Parameters:
- DATA_W, 8, width of one entry (matches MAX_UART_DATA_W).
- DEPTH_LOG2, 4, log2 of entry count; DEPTH = 2**DEPTH_LOG2 = 16.
- ALMOST_FULL_THR, 12, almost_full_o asserts when count >= this value; legal range 1..DEPTH.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  synchronous clear of contents and status.
- push_i  in  1  write request, single-cycle qualifier.
- wr_data_i  in  DATA_W  write data, sampled when push_i=1.
- pop_i  in  1  read request, single-cycle qualifier.
- rd_data_o  out  DATA_W  read data.
- rd_valid_o  out  1  rd_data_o holds a valid entry (meaning depends on macro).
- full_o  out  1  count == DEPTH.
- empty_o  out  1  count == 0.
- almost_full_o  out  1  count >= ALMOST_FULL_THR.
- count_o  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- clr_err_i  in  1  clears sticky error flags.
- overflow_o  out  1  sticky: push attempted while full.
- underflow_o  out  1  sticky: pop attempted while empty.

Behaviour:
- Clock and reset: one clock (clk_i); rst_i is synchronous, active-high.
- Reset values:
  - wr_ptr=0, rd_ptr=0, count_o=0.
  - empty_o=1, full_o=0, almost_full_o=0.
  - rd_data_o=0, rd_valid_o=0.
  - overflow_o=0, underflow_o=0.
  - Memory contents are not reset.
- Pointers: wr_ptr and rd_ptr are DEPTH_LOG2 wide and wrap modulo DEPTH (15 -> 0) with no extra state. Full/empty are derived from the registered count.
- Accepted push: push_i=1 and (!full_o, or pop accepted in the same cycle).
  - mem[wr_ptr] <= wr_data_i.
  - wr_ptr increments.
- Rejected push: push_i=1 while full_o=1 with no accepted pop.
  - Data is dropped; pointers and count are unchanged.
  - overflow_o <= 1 next cycle.
- Accepted pop: pop_i=1 and !empty_o.
  - rd_ptr increments.
- Rejected pop: pop_i=1 while empty_o=1.
  - Pointers and count are unchanged; underflow_o <= 1.
  - A push in the same cycle is still accepted; pop does not bypass the push.
- Count update: count_o updates one cycle after the request. +1 for push only, -1 for pop only, unchanged for both accepted or neither.
- Simultaneous push and pop:
  - When full: both are accepted and count stays at DEPTH.
  - When empty: only the push is accepted and underflow is flagged.
- Status outputs: full_o, empty_o and almost_full_o are decoded from the registered count, so they are glitch-free.
- Error flags: overflow_o and underflow_o stay high until clr_err_i, flush_i or rst_i. If clr_err_i coincides with a new error event, the set wins.
- Priority: rst_i > flush_i > push/pop.
  - flush_i zeroes pointers, count, rd_valid_o and both error flags in one cycle.
  - push/pop in the flush cycle are ignored and raise no error.
- Reset mid-transfer: partially consumed contents are discarded. The first push after reset lands at index 0.

Optional Feature:
Macro: UART_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rd_data_o = mem[rd_ptr] combinationally; rd_valid_o = !empty_o.
  - The head is visible before pop; pop_i acknowledges it and the next entry appears in the following cycle.
  - Zero read latency.
- Undefined (standard, default):
  - rd_data_o is a register loaded with mem[rd_ptr] on an accepted pop.
  - rd_valid_o pulses high for exactly one cycle, one cycle after the accepted pop.
  - rd_data_o holds its value afterwards.
  - Rejected pops produce no rd_valid_o pulse.

Test Plan:
- Fill/drain: after reset, push 0x00..0x0F (16 cycles) -> full_o=1 and count_o=16; almost_full_o rises when count hits 12. Pop 16 times -> data out in order 0x00..0x0F; empty_o=1; no error flags.
- Overflow: from full, push 0xAA -> overflow_o=1, count_o stays 16, 0xAA never read. Assert clr_err_i -> overflow_o=0 next cycle.
- Underflow with concurrent push: from empty, pop_i=1 and push_i=1 with data 0x5C in the same cycle -> underflow_o=1, count_o=1; the following pop returns 0x5C.
- Wrap-around: push 10, pop 10, then push 12 values 0x40..0x4B interleaved with pops -> pointers cross 15 -> 0 and output order is preserved.
- Full simultaneous push/pop: at count 16, push 0x77 and pop together -> count_o stays 16, no overflow; 0x77 is read last.
- Flush and reset mid-stream: with count 5, flush_i together with push -> count_o=0 and flags cleared. Then, with count 5, assert rst_i -> all outputs at reset values and the next push is stored at index 0. Run both with and without UART_FIFO_FWFT_EN, checking rd_valid_o timing: combinational (FWFT) vs one-cycle pulse after pop (standard).
